// File: rtl/memory_access.sv
// RV32I memory-access stage: data-memory request/grant/response handshake, lane steering,
// load extension and the MEM/WB register that drives the register-file write port.
module memory_access #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_ADDR   = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clk_en,
    input  logic                  i_ex_valid,
    input  logic [DATA_WIDTH-1:0] i_ex_alu_result,
    input  logic [DATA_WIDTH-1:0] i_ex_rs2_data,
    input  logic [REG_ADDR-1:0]   i_ex_reg_destination,
    input  logic                  i_ex_reg_wr,
    input  logic                  i_ex_mem_rd,
    input  logic                  i_ex_mem_wr,
    input  logic                  i_ex_mem_to_reg,
    input  logic [2:0]            i_ex_funct3,
    output logic                  o_dmem_req,
    output logic                  o_dmem_we,
    output logic [DATA_WIDTH-1:0] o_dmem_addr,
    output logic [3:0]            o_dmem_be,
    output logic [DATA_WIDTH-1:0] o_dmem_wdata,
    input  logic                  i_dmem_gnt,
    input  logic                  i_dmem_rvalid,
    input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
    output logic                  o_stall,
    output logic                  o_misaligned,
    output logic                  o_ma_reg_wr,
    output logic [REG_ADDR-1:0]   o_ma_reg_destination,
    output logic [DATA_WIDTH-1:0] o_wb_data,
    output logic [1:0]            o_fsm_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        WAIT_R = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [DATA_WIDTH-1:0]   load_buf_q;
    logic                    misaligned_q;
    logic                    ma_reg_wr_q;
    logic [REG_ADDR-1:0]     ma_reg_destination_q;
    logic [DATA_WIDTH-1:0]   wb_data_q;

    logic                    memop;
    logic                    misaligned_c;
    logic                    aligned_op;
    logic                    req_c;
    logic                    retire_c;
    logic [DATA_WIDTH-1:0]   shifted_c;
    logic [DATA_WIDTH-1:0]   ext_c;
    logic [DATA_WIDTH-1:0]   load_data_c;

    assign memop        = i_ex_valid & (i_ex_mem_rd | i_ex_mem_wr);
    assign misaligned_c = ((i_ex_funct3[1:0] == 2'b01) & i_ex_alu_result[0]) |
                          ((i_ex_funct3[1:0] == 2'b10) & (i_ex_alu_result[1:0] != 2'b00));
    assign aligned_op   = memop & ~misaligned_c;

    // Request stays up in REQ regardless of clk_en so a pending grant is never dropped.
    assign req_c = ((state_q == IDLE) & aligned_op & clk_en) | (state_q == REQ);

    always_comb begin
        retire_c = 1'b0;
        case (state_q)
            IDLE:    retire_c = aligned_op & clk_en & i_dmem_gnt & i_ex_mem_wr;
            REQ:     retire_c = i_dmem_gnt & i_ex_mem_wr & clk_en;
            WAIT_R:  retire_c = i_dmem_rvalid & clk_en;
            DONE:    retire_c = clk_en;
            default: retire_c = 1'b0;
        endcase
    end

    assign o_stall = aligned_op & ~retire_c;

    always_comb begin
        shifted_c = i_dmem_rdata >> {i_ex_alu_result[1:0], 3'b000};
        case (i_ex_funct3)
            3'b000:  ext_c = {{24{shifted_c[7]}}, shifted_c[7:0]};
            3'b001:  ext_c = {{16{shifted_c[15]}}, shifted_c[15:0]};
            3'b100:  ext_c = {24'd0, shifted_c[7:0]};
            3'b101:  ext_c = {16'd0, shifted_c[15:0]};
            default: ext_c = i_dmem_rdata;
        endcase
    end

    assign load_data_c = (state_q == DONE) ? load_buf_q : ext_c;

    always_comb begin
        o_dmem_req   = req_c;
        o_dmem_we    = 1'b0;
        o_dmem_addr  = '0;
        o_dmem_be    = 4'b0000;
        o_dmem_wdata = '0;
        if (req_c) begin
            o_dmem_we   = i_ex_mem_wr;
            o_dmem_addr = {i_ex_alu_result[DATA_WIDTH-1:2], 2'b00};
            o_dmem_be   = 4'b1111;
            if (i_ex_mem_wr) begin
                case (i_ex_funct3[1:0])
                    2'b00: begin
                        o_dmem_be    = 4'b0001 << i_ex_alu_result[1:0];
                        o_dmem_wdata = {4{i_ex_rs2_data[7:0]}};
                    end
                    2'b01: begin
                        o_dmem_be    = 4'b0011 << i_ex_alu_result[1:0];
                        o_dmem_wdata = {2{i_ex_rs2_data[15:0]}};
                    end
                    default: o_dmem_wdata = i_ex_rs2_data;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q              <= IDLE;
            load_buf_q           <= '0;
            misaligned_q         <= 1'b0;
            ma_reg_wr_q          <= 1'b0;
            ma_reg_destination_q <= '0;
            wb_data_q            <= '0;
        end else begin
            misaligned_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (aligned_op & clk_en) begin
                        if (!i_dmem_gnt)      state_q <= REQ;
                        else if (i_ex_mem_rd) state_q <= WAIT_R;
                    end
                end
                REQ: begin
                    if (i_dmem_gnt) begin
                        if (i_ex_mem_rd) state_q <= WAIT_R;
                        else             state_q <= clk_en ? IDLE : DONE;
                    end
                end
                WAIT_R: begin
                    if (i_dmem_rvalid) begin
                        load_buf_q <= ext_c;
                        state_q    <= clk_en ? IDLE : DONE;
                    end
                end
                DONE: begin
                    if (clk_en) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase

            if (clk_en) begin
                if (retire_c) begin
                    ma_reg_wr_q          <= i_ex_valid & i_ex_reg_wr;
                    ma_reg_destination_q <= i_ex_reg_destination;
                    wb_data_q            <= i_ex_mem_to_reg ? load_data_c : i_ex_alu_result;
                end else if (aligned_op) begin
                    // Bubble while stalled so the held instruction is written exactly once.
                    ma_reg_wr_q <= 1'b0;
                end else if (memop && state_q == IDLE) begin
                    ma_reg_wr_q  <= 1'b0;
                    misaligned_q <= 1'b1;
                end else begin
                    ma_reg_wr_q          <= i_ex_valid & i_ex_reg_wr;
                    ma_reg_destination_q <= i_ex_reg_destination;
                    wb_data_q            <= i_ex_alu_result;
                end
            end
        end
    end

    assign o_misaligned         = misaligned_q;
    assign o_ma_reg_wr          = ma_reg_wr_q;
    assign o_ma_reg_destination = ma_reg_destination_q;
    assign o_wb_data            = wb_data_q;
    assign o_fsm_state          = state_q;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: ALU write-back, load/store handshakes, steering,
// extension, misalignment, clk_en hold and asynchronous reset mid-transaction.
module tb_memory_access;

    logic        clk;
    logic        rst_n;
    logic        clk_en;
    logic        ex_valid;
    logic [31:0] ex_alu;
    logic [31:0] ex_rs2;
    logic [4:0]  ex_rd;
    logic        ex_reg_wr;
    logic        ex_mem_rd;
    logic        ex_mem_wr;
    logic        ex_mem_to_reg;
    logic [2:0]  ex_funct3;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic        stall;
    logic        misaligned;
    logic        ma_reg_wr;
    logic [4:0]  ma_rd;
    logic [31:0] wb_data;
    logic [1:0]  fsm_state;

    int tests_run;
    int tests_failed;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    memory_access dut (
        .clk                  (clk),
        .rst_n                (rst_n),
        .clk_en               (clk_en),
        .i_ex_valid           (ex_valid),
        .i_ex_alu_result      (ex_alu),
        .i_ex_rs2_data        (ex_rs2),
        .i_ex_reg_destination (ex_rd),
        .i_ex_reg_wr          (ex_reg_wr),
        .i_ex_mem_rd          (ex_mem_rd),
        .i_ex_mem_wr          (ex_mem_wr),
        .i_ex_mem_to_reg      (ex_mem_to_reg),
        .i_ex_funct3          (ex_funct3),
        .o_dmem_req           (dmem_req),
        .o_dmem_we            (dmem_we),
        .o_dmem_addr          (dmem_addr),
        .o_dmem_be            (dmem_be),
        .o_dmem_wdata         (dmem_wdata),
        .i_dmem_gnt           (dmem_gnt),
        .i_dmem_rvalid        (dmem_rvalid),
        .i_dmem_rdata         (dmem_rdata),
        .o_stall              (stall),
        .o_misaligned         (misaligned),
        .o_ma_reg_wr          (ma_reg_wr),
        .o_ma_reg_destination (ma_rd),
        .o_wb_data            (wb_data),
        .o_fsm_state          (fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic clear_bundle();
        clk_en        = 1'b1;
        ex_valid      = 1'b0;
        ex_alu        = 32'd0;
        ex_rs2        = 32'd0;
        ex_rd         = 5'd0;
        ex_reg_wr     = 1'b0;
        ex_mem_rd     = 1'b0;
        ex_mem_wr     = 1'b0;
        ex_mem_to_reg = 1'b0;
        ex_funct3     = 3'd0;
        dmem_gnt      = 1'b0;
        dmem_rvalid   = 1'b0;
        dmem_rdata    = 32'd0;
    endtask

    task automatic drive_load(input logic [31:0] addr, input logic [2:0] f3, input logic [4:0] rd);
        ex_valid      = 1'b1;
        ex_alu        = addr;
        ex_rd         = rd;
        ex_reg_wr     = 1'b1;
        ex_mem_rd     = 1'b1;
        ex_mem_wr     = 1'b0;
        ex_mem_to_reg = 1'b1;
        ex_funct3     = f3;
    endtask

    task automatic drive_store(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] data);
        ex_valid      = 1'b1;
        ex_alu        = addr;
        ex_rs2        = data;
        ex_rd         = 5'd0;
        ex_reg_wr     = 1'b0;
        ex_mem_rd     = 1'b0;
        ex_mem_wr     = 1'b1;
        ex_mem_to_reg = 1'b0;
        ex_funct3     = f3;
    endtask

    task automatic test_reset();
        clear_bundle();
        rst_n = 1'b0;
        #3;
        tests_run++; if (fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE); end
        tests_run++; if ({ma_reg_wr, ma_rd, wb_data, misaligned} !== 39'd0) begin tests_failed++; $display("FAIL reset_regs: got wr=%0b rd=%0d wb=%h mis=%0b want all 0", ma_reg_wr, ma_rd, wb_data, misaligned); end
        tests_run++; if ({dmem_req, dmem_we, dmem_be, stall} !== 7'd0) begin tests_failed++; $display("FAIL reset_comb: got req=%0b we=%0b be=%h stall=%0b want all 0", dmem_req, dmem_we, dmem_be, stall); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_alu();
        @(negedge clk);
        ex_valid  = 1'b1;
        ex_alu    = 32'h0000_1234;
        ex_rd     = 5'd5;
        ex_reg_wr = 1'b1;
        #1;
        tests_run++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin tests_failed++; $display("FAIL alu_no_stall: got stall=%0b req=%0b want 0 0", stall, dmem_req); end
        @(posedge clk); #1;
        tests_run++; if (ma_reg_wr !== 1'b1) begin tests_failed++; $display("FAIL alu_reg_wr: got %0b want 1", ma_reg_wr); end
        tests_run++; if (ma_rd !== 5'd5) begin tests_failed++; $display("FAIL alu_rd: got %0d want 5", ma_rd); end
        tests_run++; if (wb_data !== 32'h0000_1234) begin tests_failed++; $display("FAIL alu_wb: got %h want 00001234", wb_data); end
        @(negedge clk);
        clear_bundle();
        @(posedge clk); #1;
        tests_run++; if (ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL alu_bubble_after: got %0b want 0", ma_reg_wr); end
    endtask

    task automatic test_lb();
        @(negedge clk);
        drive_load(32'h0000_0103, 3'b000, 5'd7);
        dmem_gnt = 1'b1;
        #1;
        tests_run++; if (dmem_req !== 1'b1 || dmem_we !== 1'b0) begin tests_failed++; $display("FAIL lb_req: got req=%0b we=%0b want 1 0", dmem_req, dmem_we); end
        tests_run++; if (dmem_addr !== 32'h0000_0100) begin tests_failed++; $display("FAIL lb_addr: got %h want 00000100", dmem_addr); end
        tests_run++; if (dmem_be !== 4'b1111) begin tests_failed++; $display("FAIL lb_be: got %b want 1111", dmem_be); end
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lb_stall_c0: got %0b want 1", stall); end
        @(posedge clk); #1;
        tests_run++; if (fsm_state !== S_WAIT) begin tests_failed++; $display("FAIL lb_state_wait: got %0d want %0d", fsm_state, S_WAIT); end
        tests_run++; if (ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL lb_bubble: got %0b want 0", ma_reg_wr); end
        @(negedge clk);
        dmem_gnt    = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h80AB_CDEF;
        #1;
        tests_run++; if (stall !== 1'b0 || dmem_req !== 1'b0) begin tests_failed++; $display("FAIL lb_c1: got stall=%0b req=%0b want 0 0", stall, dmem_req); end
        @(posedge clk); #1;
        tests_run++; if (ma_reg_wr !== 1'b1 || ma_rd !== 5'd7) begin tests_failed++; $display("FAIL lb_write: got wr=%0b rd=%0d want 1 7", ma_reg_wr, ma_rd); end
        tests_run++; if (wb_data !== 32'hFFFF_FF80) begin tests_failed++; $display("FAIL lb_wb: got %h want ffffff80", wb_data); end
        tests_run++; if (fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL lb_state_idle: got %0d want %0d", fsm_state, S_IDLE); end
        @(negedge clk);
        clear_bundle();
        @(posedge clk); #1;
        tests_run++; if (ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL lb_single_write: got %0b want 0", ma_reg_wr); end
    endtask

    task automatic test_sh_delayed_gnt();
        @(negedge clk);
        drive_store(32'h0000_0202, 3'b001, 32'h1234_5678);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) @(negedge clk);
            dmem_gnt = (i == 3);
            #1;
            tests_run++; if (dmem_req !== 1'b1 || dmem_we !== 1'b1) begin tests_failed++; $display("FAIL sh_req_c%0d: got req=%0b we=%0b want 1 1", i, dmem_req, dmem_we); end
            tests_run++; if (dmem_be !== 4'b1100 || dmem_wdata !== 32'h5678_5678 || dmem_addr !== 32'h0000_0200) begin tests_failed++; $display("FAIL sh_lanes_c%0d: got be=%b wd=%h a=%h want 1100 56785678 00000200", i, dmem_be, dmem_wdata, dmem_addr); end
            tests_run++; if (stall !== (i < 3)) begin tests_failed++; $display("FAIL sh_stall_c%0d: got %0b want %0b", i, stall, (i < 3)); end
            @(posedge clk); #1;
            tests_run++; if (ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL sh_reg_wr_c%0d: got %0b want 0", i, ma_reg_wr); end
            tests_run++; if (fsm_state !== ((i == 3) ? S_IDLE : S_REQ)) begin tests_failed++; $display("FAIL sh_state_c%0d: got %0d want %0d", i, fsm_state, ((i == 3) ? S_IDLE : S_REQ)); end
        end
        @(negedge clk);
        clear_bundle();
        #1;
        tests_run++; if (dmem_req !== 1'b0) begin tests_failed++; $display("FAIL sh_req_drop: got %0b want 0", dmem_req); end
    endtask

    localparam logic [31:0] ST_ADDR [3] = '{32'h0000_0301, 32'h0000_0400, 32'h0000_0003};
    localparam logic [2:0]  ST_F3   [3] = '{3'b000, 3'b010, 3'b000};
    localparam logic [31:0] ST_RS2  [3] = '{32'h0000_00A5, 32'hCAFE_F00D, 32'h7777_7711};
    localparam logic [3:0]  ST_BE   [3] = '{4'b0010, 4'b1111, 4'b1000};
    localparam logic [31:0] ST_WD   [3] = '{32'hA5A5_A5A5, 32'hCAFE_F00D, 32'h1111_1111};

    task automatic test_store_steering();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive_store(ST_ADDR[i], ST_F3[i], ST_RS2[i]);
            dmem_gnt = 1'b1;
            #1;
            tests_run++; if (dmem_be !== ST_BE[i] || dmem_wdata !== ST_WD[i]) begin tests_failed++; $display("FAIL st_lanes_%0d: got be=%b wd=%h want %b %h", i, dmem_be, dmem_wdata, ST_BE[i], ST_WD[i]); end
            tests_run++; if (stall !== 1'b0 || dmem_req !== 1'b1) begin tests_failed++; $display("FAIL st_handshake_%0d: got stall=%0b req=%0b want 0 1", i, stall, dmem_req); end
            @(posedge clk); #1;
            tests_run++; if (fsm_state !== S_IDLE || ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL st_retire_%0d: got st=%0d wr=%0b want 0 0", i, fsm_state, ma_reg_wr); end
        end
        @(negedge clk);
        clear_bundle();
    endtask

    localparam logic [31:0] LD_ADDR [5] = '{32'h0000_0102, 32'h0000_0101, 32'h0000_0008, 32'h0000_0000, 32'h0000_000C};
    localparam logic [2:0]  LD_F3   [5] = '{3'b001, 3'b100, 3'b010, 3'b000, 3'b011};
    localparam logic [31:0] LD_RD   [5] = '{32'h8001_1234, 32'h0000_F000, 32'h1234_5678, 32'h0000_007F, 32'hA5A5_A5A5};
    localparam logic [31:0] LD_EXP  [5] = '{32'hFFFF_8001, 32'h0000_00F0, 32'h1234_5678, 32'h0000_007F, 32'hA5A5_A5A5};

    task automatic test_load_ext();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            drive_load(LD_ADDR[i], LD_F3[i], 5'(i + 10));
            dmem_gnt = 1'b1;
            @(negedge clk);
            dmem_gnt    = 1'b0;
            dmem_rvalid = 1'b1;
            dmem_rdata  = LD_RD[i];
            @(posedge clk); #1;
            tests_run++; if (wb_data !== LD_EXP[i] || ma_reg_wr !== 1'b1 || ma_rd !== 5'(i + 10)) begin tests_failed++; $display("FAIL ld_ext_%0d: got wb=%h wr=%0b rd=%0d want %h 1 %0d", i, wb_data, ma_reg_wr, ma_rd, LD_EXP[i], i + 10); end
            @(negedge clk);
            clear_bundle();
        end
    endtask

    task automatic test_misaligned();
        @(negedge clk);
        drive_load(32'h0000_0001, 3'b010, 5'd3);
        dmem_gnt = 1'b1;
        #1;
        tests_run++; if (dmem_req !== 1'b0 || stall !== 1'b0) begin tests_failed++; $display("FAIL mis_no_req: got req=%0b stall=%0b want 0 0", dmem_req, stall); end
        @(posedge clk); #1;
        tests_run++; if (misaligned !== 1'b1 || ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL mis_pulse: got mis=%0b wr=%0b want 1 0", misaligned, ma_reg_wr); end
        tests_run++; if (fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL mis_state: got %0d want 0", fsm_state); end
        @(negedge clk);
        clear_bundle();
        @(posedge clk); #1;
        tests_run++; if (misaligned !== 1'b0) begin tests_failed++; $display("FAIL mis_one_cycle: got %0b want 0", misaligned); end
    endtask

    task automatic test_lhu_clk_en_hold();
        @(negedge clk);
        drive_load(32'h0000_0002, 3'b101, 5'd9);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (fsm_state !== S_WAIT) begin tests_failed++; $display("FAIL lhu_wait: got %0d want %0d", fsm_state, S_WAIT); end
        @(negedge clk);
        dmem_gnt    = 1'b0;
        clk_en      = 1'b0;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hBEEF_0000;
        #1;
        tests_run++; if (stall !== 1'b1) begin tests_failed++; $display("FAIL lhu_stall_hold: got %0b want 1", stall); end
        @(posedge clk); #1;
        tests_run++; if (fsm_state !== S_DONE || ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL lhu_done: got st=%0d wr=%0b want %0d 0", fsm_state, ma_reg_wr, S_DONE); end
        @(negedge clk);
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0000_0000;
        @(posedge clk); #1;
        tests_run++; if (fsm_state !== S_DONE || ma_reg_wr !== 1'b0) begin tests_failed++; $display("FAIL lhu_done_hold: got st=%0d wr=%0b want %0d 0", fsm_state, ma_reg_wr, S_DONE); end
        @(negedge clk);
        clk_en = 1'b1;
        #1;
        tests_run++; if (stall !== 1'b0) begin tests_failed++; $display("FAIL lhu_release: got %0b want 0", stall); end
        @(posedge clk); #1;
        tests_run++; if (wb_data !== 32'h0000_BEEF || ma_reg_wr !== 1'b1 || ma_rd !== 5'd9) begin tests_failed++; $display("FAIL lhu_wb: got wb=%h wr=%0b rd=%0d want 0000beef 1 9", wb_data, ma_reg_wr, ma_rd); end
        tests_run++; if (fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL lhu_idle: got %0d want 0", fsm_state); end
        @(negedge clk);
        clear_bundle();
    endtask

    task automatic test_reset_mid_transaction();
        @(negedge clk);
        drive_load(32'h0000_0010, 3'b010, 5'd12);
        dmem_gnt = 1'b1;
        @(posedge clk); #1;
        tests_run++; if (fsm_state !== S_WAIT) begin tests_failed++; $display("FAIL rstmid_wait: got %0d want %0d", fsm_state, S_WAIT); end
        @(negedge clk);
        clear_bundle();
        rst_n = 1'b0;
        #1;
        tests_run++; if (fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL rstmid_state: got %0d want 0", fsm_state); end
        tests_run++; if ({ma_reg_wr, ma_rd, wb_data, misaligned} !== 39'd0) begin tests_failed++; $display("FAIL rstmid_regs: got wr=%0b rd=%0d wb=%h mis=%0b want all 0", ma_reg_wr, ma_rd, wb_data, misaligned); end
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hDEAD_BEEF;
        @(posedge clk); #1;
        tests_run++; if (ma_reg_wr !== 1'b0 || wb_data !== 32'd0 || fsm_state !== S_IDLE) begin tests_failed++; $display("FAIL rstmid_late_rvalid: got wr=%0b wb=%h st=%0d want 0 0 0", ma_reg_wr, wb_data, fsm_state); end
        @(negedge clk);
        clear_bundle();
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_alu();
        test_lb();
        test_sh_delayed_gnt();
        test_store_steering();
        test_load_ext();
        test_misaligned();
        test_lhu_clk_en_hold();
        test_reset_mid_transaction();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
